// File: rtl/pe_mac_acc.sv
// ---------------------------------------------------------------------------
// pe_mac_acc -- multi-lane multiply-accumulate processing element
//
// Each accepted input beat multiplies LANES ifmap/weight pairs, sums the
// products and adds the sum into a group accumulator. A group is a run of
// beats closed by in_last. The first beat of a group also supplies the bias
// and the operand mode; both are ignored on later beats. The finished group
// sum is presented on a valid/ready output one clock after the last beat.
//
// Parameters:
//   LANES  number of ifmap/weight pairs per beat
//   IW     ifmap element width
//   WW     weight element width
//   ACC_W  accumulator / bias / opsum width (two's complement, wraps)
//   CNT_W  beat counter width (wraps)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; drops any open group
//   signed_mode  1: operands sign-extended, 0: zero-extended (first beat)
//   relu         clamp negative results to zero (last beat, PE_RELU_EN only)
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid && in_ready
//   in_last      final beat of the group
//   ifmap        LANES packed IW-bit elements, lane 0 in the LSBs
//   weight       LANES packed WW-bit elements, lane 0 in the LSBs
//   bias         signed group bias (first beat)
//   out_valid    opsum/beat_cnt hold a finished group
//   out_ready    downstream takes the result
//   opsum        signed group result
//   beat_cnt     number of beats in the delivered group
//   dbg_state    group FSM state (0: IDLE, 1: ACC)
//
// Build option: define PE_RELU_EN to honour the relu input. Without it the
// relu port is present but has no effect and opsum is the raw wrapped sum.
// ---------------------------------------------------------------------------
module pe_mac_acc #(
    parameter int LANES = 4,
    parameter int IW    = 8,
    parameter int WW    = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_mode,
    input  logic                  relu,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [LANES*IW-1:0]   ifmap,
    input  logic [LANES*WW-1:0]   weight,
    input  logic [ACC_W-1:0]      bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      opsum,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic [0:0]            dbg_state
);

    // Width of one lane product: (IW+1) x (WW+1) signed operands.
    localparam int PW = IW + WW + 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    logic [0:0]              state;
    logic                    mode_q;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    logic                    mode_eff;
    logic signed [ACC_W-1:0] prod_ext [LANES];
    logic signed [ACC_W-1:0] lane_sum;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] result;
    logic [CNT_W-1:0]        cnt_next;
    logic                    fire;

    // Handshake: a beat moves when in_valid && in_ready, the result moves
    // when out_valid && out_ready. in_ready only depends on the output
    // register being free or draining this cycle, so a new result may land
    // in the same cycle the old one leaves. While a result is stalled
    // nothing upstream is consumed and the accumulator is frozen.
    assign in_ready  = !out_valid || out_ready;
    assign fire      = in_valid && in_ready;
    assign dbg_state = state;

    // The first beat of a group uses the live mode input; later beats use
    // the mode latched on that first beat.
    assign mode_eff = (state == S_IDLE) ? signed_mode : mode_q;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic signed [IW:0]   a_ext;
            logic signed [WW:0]   b_ext;
            logic signed [PW-1:0] prod;

            // One extra bit per operand lets both modes share a single
            // signed multiplier: the top bit is the sign copy or zero.
            assign a_ext = {mode_eff & ifmap[g*IW+IW-1],  ifmap[g*IW +: IW]};
            assign b_ext = {mode_eff & weight[g*WW+WW-1], weight[g*WW +: WW]};
            assign prod  = a_ext * b_ext;
            assign prod_ext[g] = ACC_W'(prod);
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + prod_ext[l];
        end
    end

    // The bias seeds the first beat; later beats add onto the accumulator.
    assign base     = (state == S_IDLE) ? $signed(bias) : acc;
    assign sum      = base + lane_sum;
    assign cnt_next = (state == S_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);

`ifdef PE_RELU_EN
    assign result = (relu && sum[ACC_W-1]) ? '0 : sum;
`else
    // relu is a don't-care in this build; the port is kept so both builds
    // share one footprint.
    assign result = (relu & 1'b0) ? '0 : sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            opsum     <= '0;
            beat_cnt  <= '0;
        end else begin
            // Drain first; an accepted last beat below overrides this.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (fire) begin
                if (in_last) begin
                    opsum     <= result;
                    beat_cnt  <= cnt_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    state     <= S_IDLE;
                end else begin
                    acc   <= sum;
                    cnt   <= cnt_next;
                    state <= S_ACC;
                    if (state == S_IDLE) begin
                        mode_q <= signed_mode;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_acc -- self-checking bench for pe_mac_acc
//
// Directed single-beat vector table, hand-written multi-cycle sequences
// (multi-beat groups, back-pressure, same-cycle replace, reset mid-group)
// and randomized groups checked through an expected queue filled from an
// arithmetic reference model. Define PE_RELU_EN for both bench and RTL to
// exercise the ReLU build.
// ---------------------------------------------------------------------------
module tb_pe_mac_acc;

    localparam int LANES = 4;
    localparam int IW    = 8;
    localparam int WW    = 8;
    localparam int ACC_W = 32;
    localparam int CNT_W = 16;

    logic                  clk;
    logic                  rst;
    logic                  signed_mode;
    logic                  relu;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [LANES*IW-1:0]   ifmap;
    logic [LANES*WW-1:0]   weight;
    logic [ACC_W-1:0]      bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      opsum;
    logic [CNT_W-1:0]      beat_cnt;
    logic [0:0]            dbg_state;

    pe_mac_acc #(
        .LANES(LANES), .IW(IW), .WW(WW), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .signed_mode(signed_mode), .relu(relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .ifmap(ifmap), .weight(weight), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .opsum(opsum), .beat_cnt(beat_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic rnd_bp = 1'b0;
    logic sb_en  = 1'b0;

    logic [ACC_W+CNT_W-1:0] exp_q[$];
    logic [LANES*IW-1:0]    g_ifm[$];
    logic [LANES*WW-1:0]    g_wgt[$];

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Presents one beat and returns at posedge+1 after it was accepted.
    task automatic send_beat(input logic mode, input logic [LANES*IW-1:0] ifm,
                             input logic [LANES*WW-1:0] wgt, input logic [ACC_W-1:0] b,
                             input logic last, input logic rl);
        int waited;
        waited      = 0;
        signed_mode = mode;
        ifmap       = ifm;
        weight      = wgt;
        bias        = b;
        in_last     = last;
        relu        = rl;
        in_valid    = 1'b1;
        #1;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_wait: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- reference model ----------------
    function automatic longint elem(input longint v, input int w, input logic m);
        longint x;
        x = v;
        if (m && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Group sum from the beats stored in g_ifm/g_wgt, using first-beat
    // mode and bias and last-beat relu.
    function automatic logic [ACC_W-1:0] ref_group(input logic mode,
                                                   input logic [ACC_W-1:0] b,
                                                   input logic rl);
        longint s;
        logic [63:0] s_bits;
        logic [ACC_W-1:0] r;
        s = longint'($signed(b));
        for (int k = 0; k < g_ifm.size(); k++) begin
            for (int l = 0; l < LANES; l++) begin
                s = s + elem(longint'((g_ifm[k] >> (l * IW)) & ((1 << IW) - 1)), IW, mode)
                      * elem(longint'((g_wgt[k] >> (l * WW)) & ((1 << WW) - 1)), WW, mode);
            end
        end
        s_bits = s;
        r = s_bits[ACC_W-1:0];
`ifdef PE_RELU_EN
        if (rl && r[ACC_W-1]) r = '0;
`else
        if (rl) r = r;
`endif
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [ACC_W+CNT_W-1:0] e;
                e = exp_q.pop_front();
                check("sb_opsum", opsum, e[ACC_W+CNT_W-1:CNT_W]);
                check("sb_beat_cnt", ACC_W'(beat_cnt), ACC_W'(e[CNT_W-1:0]));
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic              mode;
        logic [31:0]       ifm;
        logic [31:0]       wgt;
        logic [ACC_W-1:0]  bias;
        logic              rl;
        logic [ACC_W-1:0]  exp_sum;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [ACC_W-1:0] relu_wrap_exp;
        logic [ACC_W-1:0] relu_neg_exp;
`ifdef PE_RELU_EN
        relu_wrap_exp = 32'h0;
        relu_neg_exp  = 32'h0;
`else
        relu_wrap_exp = 32'h8000_0003;
        relu_neg_exp  = 32'hFFFF_FF00;
`endif
        vecs[0] = '{1'b0, 32'h0202_0202, 32'h0303_0303, 32'd5,          1'b0, 32'd29};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0202_0202, 32'd0,          1'b0, 32'hFFFF_FFF8};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0202_0202, 32'd0,          1'b0, 32'd2040};
        vecs[3] = '{1'b1, 32'h8080_8080, 32'h8080_8080, 32'd0,          1'b0, 32'd65536};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1'b0, 32'd260100};
        vecs[5] = '{1'b1, 32'h0102_0304, 32'hFF01_0101, 32'd0,          1'b0, 32'd8};
        vecs[6] = '{1'b0, 32'h0101_0101, 32'h0101_0101, 32'h7FFF_FFFF, 1'b0, 32'h8000_0003};
        vecs[7] = '{1'b0, 32'h0101_0101, 32'h0101_0101, 32'h7FFF_FFFF, 1'b1, relu_wrap_exp};
        vecs[8] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FF00, 1'b1, relu_neg_exp};

        rst = 1'b1; signed_mode = 1'b0; relu = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        ifmap = '0; weight = '0; bias = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_opsum", opsum, 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-beat table
        for (int i = 0; i < 9; i++) begin
            send_beat(vecs[i].mode, vecs[i].ifm, vecs[i].wgt, vecs[i].bias, 1'b1, vecs[i].rl);
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_opsum", i), opsum, vecs[i].exp_sum);
            check($sformatf("vec%0d_beat_cnt", i), 32'(beat_cnt), 32'd1);
            tick();
        end
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // 3-beat groups, signed then unsigned
        for (int m = 1; m >= 0; m--) begin
            send_beat(m[0], 32'hFFFF_FFFF, 32'h0202_0202, 32'd0, 1'b0, 1'b0);
            send_beat(m[0], 32'hFFFF_FFFF, 32'h0202_0202, 32'd0, 1'b0, 1'b0);
            send_beat(m[0], 32'hFFFF_FFFF, 32'h0202_0202, 32'd0, 1'b1, 1'b0);
            check($sformatf("grp3_m%0d_opsum", m), opsum, (m == 1) ? 32'hFFFF_FFE8 : 32'd6120);
            check($sformatf("grp3_m%0d_beat_cnt", m), 32'(beat_cnt), 32'd3);
            tick();
        end

        // Back-pressure: held result, stalled input
        out_ready = 1'b0;
        send_beat(1'b0, 32'h0202_0202, 32'h0303_0303, 32'd5, 1'b1, 1'b0);
        check("bp_first_opsum", opsum, 32'd29);
        signed_mode = 1'b0; ifmap = '0; weight = '0; bias = 32'd100;
        in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_opsum", opsum, 32'd29);
            check("bp_hold_beat_cnt", 32'(beat_cnt), 32'd1);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_new_opsum", opsum, 32'd100);

        // Same-cycle replace
        send_beat(1'b0, 32'h0, 32'h0, 32'd7, 1'b1, 1'b0);
        check("replace_valid", 32'(out_valid), 32'd1);
        check("replace_opsum", opsum, 32'd7);
        check("replace_beat_cnt", 32'(beat_cnt), 32'd1);
        tick();
        check("replace_drain", 32'(out_valid), 32'd0);

        // Reset mid-group discards the partial sum
        send_beat(1'b0, 32'h0505_0505, 32'h0707_0707, 32'd1000, 1'b0, 1'b0);
        send_beat(1'b0, 32'h0505_0505, 32'h0707_0707, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_opsum", opsum, 32'd0);
        send_beat(1'b0, 32'h0101_0101, 32'h0101_0101, 32'd0, 1'b1, 1'b0);
        check("midrst_next_opsum", opsum, 32'd4);
        check("midrst_next_beat_cnt", 32'(beat_cnt), 32'd1);
        tick();

        // Randomized groups with back-pressure, gaps and mid-group noise
        sb_en  = 1'b1;
        rnd_bp = 1'b1;
        for (int grp = 0; grp < 40; grp++) begin
            int n;
            logic m0;
            logic [ACC_W-1:0] b0;
            logic rl;
            n  = $urandom_range(1, 5);
            m0 = $urandom_range(0, 1);
            b0 = $urandom();
            rl = $urandom_range(0, 1);
            g_ifm.delete();
            g_wgt.delete();
            for (int k = 0; k < n; k++) begin
                logic [LANES*IW-1:0] fi;
                logic [LANES*WW-1:0] fw;
                fi = $urandom();
                fw = $urandom();
                g_ifm.push_back(fi);
                g_wgt.push_back(fw);
                if (k == n - 1) exp_q.push_back({ref_group(m0, b0, rl), CNT_W'(n)});
                if ($urandom_range(0, 3) == 0) tick();
                send_beat((k == 0) ? m0 : 1'($urandom_range(0, 1)), fi, fw,
                          (k == 0) ? b0 : ACC_W'($urandom()), (k == n - 1),
                          (k == n - 1) ? rl : 1'($urandom_range(0, 1)));
            end
        end
        rnd_bp    = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
